ifu_fetch: RTL and testbench

//  Instruction fetch unit; sits directly upstream of the IF/ID pipeline register.

---
 rtl/ifu_fetch_pkg.sv | 23 ++
 rtl/ifu_skid_buf.sv | 38 +++
 rtl/ifu_fetch.sv | 122 ++++++++++++
 tb/tb_ifu_fetch.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_pkg : shared widths, NOP encoding and FSM state type for the IFU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ifu_fetch_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ROM_DEPTH    = 4096;
  localparam int ADDR_WIDTH   = $clog2(ROM_DEPTH);
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int IFU_RESET_PC = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_skid_buf.sv
// ---------------------------------------------------------------------------
// ifu_skid_buf : one-entry {instr, addr} holding register; clear beats load
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ifu_skid_buf #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] load_instr,
  input  logic [AW-1:0] load_addr,
  output logic          skid_vld,
  output logic [DW-1:0] skid_instr,
  output logic [AW-1:0] skid_addr
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid_vld   <= 1'b0;
      skid_instr <= '0;
      skid_addr  <= '0;
    end else if (clear) begin
      skid_vld   <= 1'b0;
    end else if (load) begin
      skid_vld   <= 1'b1;
      skid_instr <= load_instr;
      skid_addr  <= load_addr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch : PC owner and ROM driver feeding IF/ID, with stall skid and jump
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH,
  parameter logic [AW-1:0] RESET_PC = AW'(IFU_RESET_PC)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          hold_flag_i_ctrl_ifu,
  input  logic          jump_flag_i_ctrl_ifu,
  input  logic [AW-1:0] jump_addr_i_ctrl_ifu,
  output logic          rom_ce_o_ifu_rom,
  output logic [AW-1:0] rom_addr_o_ifu_rom,
  input  logic [DW-1:0] rom_data_i_rom_ifu,
  output logic [DW-1:0] instr_o_ifu_ifu2idu,
  output logic [AW-1:0] instr_addr_o_ifu_ifu2idu
);

  localparam logic [DW-1:0] NOP = DW'(INSTR_NOP);

  ifu_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          req_vld_q, req_vld_d;
  logic [AW-1:0] target;
  logic          ce;
  logic          skid_load, skid_clear, skid_vld;
  logic [DW-1:0] skid_instr;
  logic [AW-1:0] skid_addr;
  logic          out_vld;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_addr;

  assign target = jump_addr_i_ctrl_ifu & ~AW'(3);

  ifu_skid_buf #(.DW(DW), .AW(AW)) u_skid (
    .clk        (clk),
    .rstn       (rstn),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (out_instr),
    .load_addr  (out_addr),
    .skid_vld   (skid_vld),
    .skid_instr (skid_instr),
    .skid_addr  (skid_addr)
  );

  always_comb begin
    out_vld   = 1'b0;
    out_instr = NOP;
    out_addr  = '0;
    if (skid_vld) begin
      out_vld   = 1'b1;
      out_instr = skid_instr;
      out_addr  = skid_addr;
    end else if (req_vld_q) begin
      out_vld   = 1'b1;
      out_instr = rom_data_i_rom_ifu;
      out_addr  = req_addr_q;
    end
  end

  // A redirect squashes whatever would be presented this cycle.
  assign instr_o_ifu_ifu2idu      = (rstn && !jump_flag_i_ctrl_ifu) ? out_instr : NOP;
  assign instr_addr_o_ifu_ifu2idu = (rstn && !jump_flag_i_ctrl_ifu) ? out_addr  : '0;
  assign rom_ce_o_ifu_rom         = rstn & ce;

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    req_addr_d         = req_addr_q;
    req_vld_d          = req_vld_q;
    skid_load          = 1'b0;
    skid_clear         = 1'b0;
    ce                 = 1'b0;
    rom_addr_o_ifu_rom = pc_q;
    if (jump_flag_i_ctrl_ifu) begin
      ce                 = 1'b1;
      rom_addr_o_ifu_rom = target;
      req_addr_d         = target;
      req_vld_d          = 1'b1;
      pc_d               = target + AW'(4);
      skid_clear         = 1'b1;
      state_d            = S_RUN;
    end else if (hold_flag_i_ctrl_ifu) begin
      req_vld_d = 1'b0;
      skid_load = (state_q != S_HOLD) && out_vld && !skid_vld;
      state_d   = S_HOLD;
    end else begin
      ce         = 1'b1;
      req_addr_d = pc_q;
      req_vld_d  = 1'b1;
      pc_d       = pc_q + AW'(4);
      skid_clear = (state_q == S_HOLD);
      state_d    = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      req_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      req_vld_q  <= req_vld_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch : scoreboard bench for ifu_fetch with a 1-cycle synchronous ROM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        hold = 1'b0;
  logic        jump = 1'b0;
  logic [11:0] jaddr = '0;
  logic        rom_ce;
  logic [11:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] instr;
  logic [11:0] iaddr;

  logic [31:0] rom [1024];

  typedef struct packed {
    logic [31:0] instr;
    logic [11:0] addr;
    logic        ce;
    logic        chk_ra;
    logic [11:0] ra;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc_no = 0;

  ifu_fetch dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .hold_flag_i_ctrl_ifu     (hold),
    .jump_flag_i_ctrl_ifu     (jump),
    .jump_addr_i_ctrl_ifu     (jaddr),
    .rom_ce_o_ifu_rom         (rom_ce),
    .rom_addr_o_ifu_rom       (rom_addr),
    .rom_data_i_rom_ifu       (rom_data),
    .instr_o_ifu_ifu2idu      (instr),
    .instr_addr_o_ifu_ifu2idu (iaddr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_ce) rom_data <= rom[rom_addr[11:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive controls, push the expected output, compare on the falling edge.
  task automatic cyc(input logic h, input logic j, input logic [11:0] ja,
                     input logic v, input logic [11:0] ea, input logic ce,
                     input logic chk_ra, input logic [11:0] ra);
    exp_t e;
    cyc_no++;
    hold  = h;
    jump  = j;
    jaddr = ja;
    e.instr  = v ? (32'h100 + 32'(ea >> 2)) : NOP;
    e.addr   = v ? ea : 12'h000;
    e.ce     = ce;
    e.chk_ra = chk_ra;
    e.ra     = ra;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check($sformatf("c%0d instr", cyc_no), instr, e.instr);
    check($sformatf("c%0d addr", cyc_no), 32'(iaddr), 32'(e.addr));
    check($sformatf("c%0d ce", cyc_no), 32'(rom_ce), 32'(e.ce));
    if (e.chk_ra) check($sformatf("c%0d rom_addr", cyc_no), 32'(rom_addr), 32'(e.ra));
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h100 + 32'(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset instr", instr, NOP);
    check("reset addr", 32'(iaddr), 32'h0);
    check("reset ce", 32'(rom_ce), 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // streaming from reset
    cyc(0, 0, 12'h000, 0, 12'h000, 1, 1, 12'h000);
    cyc(0, 0, 12'h000, 1, 12'h000, 1, 1, 12'h004);
    cyc(0, 0, 12'h000, 1, 12'h004, 1, 0, 12'h000);
    // 3-cycle hold with addr 8 on the output, then release
    cyc(1, 0, 12'h000, 1, 12'h008, 0, 0, 12'h000);
    cyc(1, 0, 12'h000, 1, 12'h008, 0, 0, 12'h000);
    cyc(1, 0, 12'h000, 1, 12'h008, 0, 0, 12'h000);
    cyc(0, 0, 12'h000, 1, 12'h008, 1, 1, 12'h00C);
    cyc(0, 0, 12'h000, 1, 12'h00C, 1, 0, 12'h000);
    // jump while running
    cyc(0, 1, 12'h040, 0, 12'h000, 1, 1, 12'h040);
    cyc(0, 0, 12'h000, 1, 12'h040, 1, 0, 12'h000);
    cyc(0, 0, 12'h000, 1, 12'h044, 1, 0, 12'h000);
    // jump and hold together
    cyc(1, 1, 12'h080, 0, 12'h000, 1, 1, 12'h080);
    cyc(0, 0, 12'h000, 1, 12'h080, 1, 0, 12'h000);
    cyc(1, 0, 12'h000, 1, 12'h084, 0, 0, 12'h000);
    cyc(1, 1, 12'h0A0, 0, 12'h000, 1, 1, 12'h0A0);
    cyc(0, 0, 12'h000, 1, 12'h0A0, 1, 0, 12'h000);
    // jump on the hold-release cycle discards the skid
    cyc(1, 0, 12'h000, 1, 12'h0A4, 0, 0, 12'h000);
    cyc(1, 0, 12'h000, 1, 12'h0A4, 0, 0, 12'h000);
    cyc(0, 1, 12'h0C0, 0, 12'h000, 1, 1, 12'h0C0);
    cyc(0, 0, 12'h000, 1, 12'h0C0, 1, 0, 12'h000);
    cyc(0, 0, 12'h000, 1, 12'h0C4, 1, 0, 12'h000);
    // PC wrap and unaligned jump target
    cyc(0, 1, 12'hFF8, 0, 12'h000, 1, 1, 12'hFF8);
    cyc(0, 0, 12'h000, 1, 12'hFF8, 1, 1, 12'hFFC);
    cyc(0, 0, 12'h000, 1, 12'hFFC, 1, 1, 12'h000);
    cyc(0, 0, 12'h000, 1, 12'h000, 1, 0, 12'h000);
    cyc(0, 1, 12'h043, 0, 12'h000, 1, 1, 12'h040);
    cyc(0, 0, 12'h000, 1, 12'h040, 1, 0, 12'h000);
    cyc(0, 0, 12'h000, 1, 12'h044, 1, 0, 12'h000);
    // hold with skid full, then async reset mid-hold
    cyc(1, 0, 12'h000, 1, 12'h048, 0, 0, 12'h000);
    cyc(1, 0, 12'h000, 1, 12'h048, 0, 0, 12'h000);
    hold = 1'b0;
    rstn = 1'b0;
    #1;
    check("async rst instr", instr, NOP);
    check("async rst addr", 32'(iaddr), 32'h0);
    check("async rst ce", 32'(rom_ce), 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    cyc(0, 0, 12'h000, 0, 12'h000, 1, 1, 12'h000);
    cyc(0, 0, 12'h000, 1, 12'h000, 1, 1, 12'h004);
    cyc(0, 0, 12'h000, 1, 12'h004, 1, 0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
